// File: rtl/ps2_scancode_sequencer.sv
// PS/2 keyboard front end: oversampled framing, E0/F0 prefix decode and
// a show-ahead event FIFO behind a valid/ready handshake.
module ps2_scancode_sequencer #(
   parameter int TIMEOUT_CYC = 200000,
   parameter int FIFO_AW     = 3
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               PS2_CLK,
   input  logic               PS2_DAT,
   output logic               EVT_VALID,
   input  logic               EVT_READY,
   output logic [7:0]         EVT_CODE,
   output logic               EVT_EXT,
   output logic               EVT_BREAK,
   output logic [FIFO_AW:0]   FIFO_LEVEL,
   output logic               FRAME_ERR,
   output logic               OVERFLOW
);

   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_t;
   typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_t;

   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       clk_prev;
   logic       fall;
   logic       dat;

   rx_t             rx_state, rx_next;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [WD_W-1:0] wd_cnt;
   logic            timeout;
   logic            stop_ok;
   logic            byte_stb;
   logic [7:0]      byte_q;

   dec_t d_state, d_next;
   logic push;
   logic is_ext, is_brk;

   logic [9:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   level;
   logic [9:0]         head, last_q;
   logic               full, pop, wr_en;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
         clk_prev <= clk_sync[1];
      end
   end

   assign fall    = clk_prev & ~clk_sync[1];
   assign dat     = dat_sync[1];
   assign timeout = (rx_state != RX_IDLE) && (wd_cnt == WD_MAX);
   // odd parity over data plus parity bit, and a high stop bit
   assign stop_ok = ((^shreg) ^ par_bit) & dat;

   always_comb begin
      rx_next = rx_state;
      if (timeout) begin
         rx_next = RX_IDLE;
      end else if (fall) begin
         unique case (rx_state)
            RX_IDLE: if (!dat) rx_next = RX_DATA;
            RX_DATA: if (bit_cnt == 3'd7) rx_next = RX_PAR;
            RX_PAR:  rx_next = RX_STOP;
            RX_STOP: rx_next = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_state  <= RX_IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         par_bit   <= 1'b0;
         wd_cnt    <= '0;
         byte_stb  <= 1'b0;
         byte_q    <= 8'h00;
         FRAME_ERR <= 1'b0;
      end else begin
         rx_state  <= rx_next;
         byte_stb  <= 1'b0;
         FRAME_ERR <= timeout;
         if (rx_state == RX_IDLE || fall) wd_cnt <= '0;
         else                             wd_cnt <= wd_cnt + WD_W'(1);
         if (!timeout && fall) begin
            if (rx_state == RX_IDLE) bit_cnt <= 3'd0;
            if (rx_state == RX_DATA) begin
               shreg   <= {dat, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (rx_state == RX_PAR) par_bit <= dat;
            if (rx_state == RX_STOP) begin
               byte_stb  <= stop_ok;
               byte_q    <= shreg;
               FRAME_ERR <= ~stop_ok;
            end
         end
      end
   end

   assign is_ext = (d_state == D_EXT) || (d_state == D_EXT_BRK);
   assign is_brk = (d_state == D_BRK) || (d_state == D_EXT_BRK);

   always_comb begin
      d_next = d_state;
      push   = 1'b0;
      if (FRAME_ERR) begin
         d_next = D_IDLE;
      end else if (byte_stb) begin
         unique case (1'b1)
            byte_q == 8'hE0: d_next = D_EXT;
            byte_q == 8'hF0: d_next = is_ext ? D_EXT_BRK : D_BRK;
            byte_q == 8'h00 || byte_q == 8'hFF: d_next = D_IDLE;
            default: begin
               push   = 1'b1;
               d_next = D_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) d_state <= D_IDLE;
      else        d_state <= d_next;
   end

   assign EVT_VALID  = (level != '0);
   assign FIFO_LEVEL = level;
   assign full       = (level == FULL_LVL);
   assign pop        = EVT_VALID & EVT_READY;
   assign wr_en      = push & (~full | pop);
   assign head       = mem[rd_ptr];
   assign {EVT_EXT, EVT_BREAK, EVT_CODE} = EVT_VALID ? head : last_q;

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= {is_ext, is_brk, byte_q};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         last_q   <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         OVERFLOW <= push & full & ~pop;
         if (EVT_VALID) last_q <= head;
         if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({wr_en, pop})
            2'b10:   level <= level + (FIFO_AW+1)'(1);
            2'b01:   level <= level - (FIFO_AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Bench for ps2_scancode_sequencer: table vectors, hand sequences for
// latency/watchdog/overflow/reset, and random bytes against a prefix model.
module tb_ps2_scancode_sequencer;

   localparam int TO   = 1000;
   localparam int AW   = 3;
   localparam int HALF = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ps2_clk = 1'b1;
   logic          ps2_dat = 1'b1;
   logic          evt_ready = 1'b0;
   logic          evt_valid, evt_ext, evt_break, frame_err, overflow;
   logic [7:0]    evt_code;
   logic [AW:0]   fifo_level;

   int tests = 0;
   int fails = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   bit mon_en = 1'b0;
   bit rnd_done = 1'b0;
   logic m_ext = 1'b0;
   logic m_brk = 1'b0;
   logic [9:0] exp_q[$];

   typedef struct {
      int          n;
      logic [23:0] bytes;
      logic        ev;
      logic [7:0]  code;
      logic        ext;
      logic        brk;
   } vec_t;
   vec_t tbl[11];

   ps2_scancode_sequencer #(.TIMEOUT_CYC(TO), .FIFO_AW(AW)) dut (
      .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .EVT_VALID(evt_valid), .EVT_READY(evt_ready), .EVT_CODE(evt_code),
      .EVT_EXT(evt_ext), .EVT_BREAK(evt_break), .FIFO_LEVEL(fifo_level),
      .FRAME_ERR(frame_err), .OVERFLOW(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (mon_en && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rnd_pop: unexpected event %h", {evt_ext, evt_break, evt_code});
         end else begin
            chk("rnd_pop", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout: bench still running, want finished");
      $fatal(1, "timeout");
   end

   task automatic ps2_bit(input logic d);
      @(posedge clk); #1 ps2_dat = d;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   // mode 0 plain, 1 pulse READY on the push edge, 2 check latency
   task automatic send_frame(input logic [7:0] b, input logic bad, input int mode);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad);
      @(posedge clk); #1 ps2_dat = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 if (mode == 1) evt_ready = 1'b1;
      @(negedge clk);
      if (mode == 2) chk("lat_early", 32'(evt_valid), 32'd0);
      @(posedge clk);
      #1 if (mode == 1) evt_ready = 1'b0;
      @(negedge clk);
      if (mode == 2) chk("lat_valid", 32'(evt_valid), 32'd1);
      repeat (HALF - 4) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] c, input logic e, input logic k);
      @(negedge clk);
      for (int i = 0; i < 50 && !evt_valid; i++) @(negedge clk);
      chk(nm, {21'd0, evt_valid, evt_ext, evt_break, evt_code}, {21'd0, 1'b1, e, k, c});
      @(posedge clk); #1 evt_ready = 1'b1;
      @(posedge clk); #1 evt_ready = 1'b0;
   endtask

   task automatic model_good(input logic [7:0] b);
      if (b == 8'hE0) begin
         m_ext = 1'b1;
         m_brk = 1'b0;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'h00 || b == 8'hFF) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         exp_q.push_back({m_ext, m_brk, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   initial begin
      int e0, o0, nbad, r;
      logic [7:0] b;
      logic bad;

      tbl[0]  = '{1, 24'h00001C, 1'b1, 8'h1C, 1'b0, 1'b0};
      tbl[1]  = '{2, 24'h0075E0, 1'b1, 8'h75, 1'b1, 1'b0};
      tbl[2]  = '{2, 24'h001CF0, 1'b1, 8'h1C, 1'b0, 1'b1};
      tbl[3]  = '{3, 24'h75F0E0, 1'b1, 8'h75, 1'b1, 1'b1};
      tbl[4]  = '{1, 24'h000000, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{2, 24'h00FFE0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6]  = '{3, 24'h14E0E0, 1'b1, 8'h14, 1'b1, 1'b0};
      tbl[7]  = '{3, 24'h12F0F0, 1'b1, 8'h12, 1'b0, 1'b1};
      tbl[8]  = '{3, 24'h70E0F0, 1'b1, 8'h70, 1'b1, 1'b0};
      tbl[9]  = '{3, 24'h2900E0, 1'b1, 8'h29, 1'b0, 1'b0};
      tbl[10] = '{1, 24'h0000FF, 1'b0, 8'h00, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {20'd0, evt_valid, fifo_level, evt_ext, evt_break, evt_code}, 32'd0);
      chk("rst_pulses", {30'd0, frame_err, overflow}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);

      send_frame(8'h1C, 1'b0, 2);
      pop_chk("t1_event", 8'h1C, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_hold", {22'd0, evt_valid, evt_ext, evt_break, evt_code}, {22'd0, 2'b00, 8'h1C});

      for (int i = 0; i < 11; i++) begin
         for (int j = 0; j < tbl[i].n; j++) send_frame(tbl[i].bytes[8*j +: 8], 1'b0, 0);
         repeat (4) @(negedge clk);
         if (tbl[i].ev)
            chk($sformatf("tbl%0d", i), {21'd0, evt_valid, evt_ext, evt_break, evt_code},
                {21'd0, 1'b1, tbl[i].ext, tbl[i].brk, tbl[i].code});
         else
            chk($sformatf("tbl%0d_none", i), {27'd0, evt_valid, fifo_level}, 32'd0);
         if (evt_valid) begin
            @(posedge clk); #1 evt_ready = 1'b1;
            @(posedge clk); #1 evt_ready = 1'b0;
         end
      end

      send_frame(8'hE0, 1'b0, 0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h75, 1'b0, 0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h1C, 1'b0, 0);
      @(negedge clk);
      chk("t2_level", 32'(fifo_level), 32'd2);
      pop_chk("t2_ev0", 8'h75, 1'b1, 1'b1);
      pop_chk("t2_ev1", 8'h1C, 1'b0, 1'b1);

      e0 = err_cnt;
      send_frame(8'hE0, 1'b0, 0);
      send_frame(8'h1C, 1'b1, 0);
      @(negedge clk);
      chk("t3_err", 32'(err_cnt - e0), 32'd1);
      chk("t3_level", 32'(fifo_level), 32'd0);
      send_frame(8'h1C, 1'b0, 0);
      pop_chk("t3_event", 8'h1C, 1'b0, 1'b0);

      e0 = err_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[0]);
      repeat (TO + 100) @(posedge clk);
      @(negedge clk);
      chk("t4_wdog", 32'(err_cnt - e0), 32'd1);
      chk("t4_level", 32'(fifo_level), 32'd0);
      send_frame(8'h16, 1'b0, 0);
      pop_chk("t4_event", 8'h16, 1'b0, 1'b0);

      o0 = ovf_cnt;
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 0);
      @(negedge clk);
      chk("t5_full", 32'(fifo_level), 32'd8);
      chk("t5_no_ovf", 32'(ovf_cnt - o0), 32'd0);
      send_frame(8'h09, 1'b0, 0);
      @(negedge clk);
      chk("t5_ovf", 32'(ovf_cnt - o0), 32'd1);
      chk("t5_full2", 32'(fifo_level), 32'd8);
      send_frame(8'h0A, 1'b0, 1);
      @(negedge clk);
      chk("t5_pp_ovf", 32'(ovf_cnt - o0), 32'd1);
      chk("t5_pp_level", 32'(fifo_level), 32'd8);
      for (int i = 2; i <= 8; i++) pop_chk($sformatf("t5_drain%0d", i), 8'(i), 1'b0, 1'b0);
      pop_chk("t5_drain_a", 8'h0A, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_empty", 32'(fifo_level), 32'd0);

      e0 = err_cnt;
      o0 = ovf_cnt;
      nbad = 0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      mon_en = 1'b1;
      fork
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 evt_ready = 1'($urandom_range(0, 1));
            end
         end
         begin
            for (int k = 0; k < 60; k++) begin
               r = $urandom_range(0, 9);
               bad = 1'b0;
               case (r)
                  0: b = 8'hE0;
                  1: b = 8'hF0;
                  2: b = $urandom_range(0, 1) ? 8'hFF : 8'h00;
                  3: begin
                     b = 8'($urandom_range(0, 255));
                     bad = 1'b1;
                  end
                  default: b = 8'($urandom_range(1, 8'hDF));
               endcase
               if (bad) begin
                  m_ext = 1'b0;
                  m_brk = 1'b0;
                  nbad++;
               end else begin
                  model_good(b);
               end
               send_frame(b, bad, 0);
               repeat ($urandom_range(0, 20)) @(posedge clk);
            end
            for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
            rnd_done = 1'b1;
         end
      join
      #1 evt_ready = 1'b0;
      @(negedge clk);
      mon_en = 1'b0;
      chk("rnd_drain", 32'(exp_q.size()), 32'd0);
      chk("rnd_errs", 32'(err_cnt - e0), 32'(nbad));
      chk("rnd_no_ovf", 32'(ovf_cnt - o0), 32'd0);

      send_frame(8'h1C, 1'b0, 0);
      send_frame(8'hE0, 1'b0, 0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      @(negedge clk);
      chk("t6_pre_level", 32'(fifo_level), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_outs", {20'd0, evt_valid, fifo_level, evt_ext, evt_break, evt_code}, 32'd0);
      chk("t6_rst_pulses", {30'd0, frame_err, overflow}, 32'd0);
      ps2_dat = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      e0 = err_cnt;
      send_frame(8'h75, 1'b0, 0);
      pop_chk("t6_event", 8'h75, 1'b0, 1'b0);
      chk("t6_no_err", 32'(err_cnt - e0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
